// File: rtl/axis_s2mm_arbiter.sv
// Frame-granular two-source AXI4-Stream arbiter with word/frame counters for the S2MM sink.
// Define AXIS_ARB_FIXED_PRIO_EN for fixed priority (source 0 wins); default is round-robin.
module axis_s2mm_arbiter #(
   parameter int unsigned C_DATA_WIDTH = 32
) (
   input  logic                    aclk,
   input  logic                    areset,
   output logic                    s0_axis_tready,
   input  logic [C_DATA_WIDTH-1:0] s0_axis_tdata,
   input  logic                    s0_axis_tvalid,
   input  logic                    s0_axis_tlast,
   output logic                    s1_axis_tready,
   input  logic [C_DATA_WIDTH-1:0] s1_axis_tdata,
   input  logic                    s1_axis_tvalid,
   input  logic                    s1_axis_tlast,
   input  logic                    m_axis_tready,
   output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tlast,
   input  logic                    clr_cnt,
   output logic                    busy,
   output logic                    grant_id,
   output logic                    last_src,
   output logic [31:0]             cnt_words,
   output logic [31:0]             cnt_frames
);

   localparam int unsigned CNT_W = 32;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic               grant_q, grant_d;
   logic               busy_q, busy_d;
   logic               pref_q, pref_d;
   logic               last_src_q, last_src_d;
   logic [CNT_W-1:0]   cnt_words_q, cnt_words_d;
   logic [CNT_W-1:0]   cnt_frames_q, cnt_frames_d;
   logic               hs;
   logic               hs_last;

   assign hs      = m_axis_tvalid & m_axis_tready;
   assign hs_last = hs & m_axis_tlast;

   // State register and registered status/counters
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q      <= S_IDLE;
         grant_q      <= 1'b0;
         busy_q       <= 1'b0;
         pref_q       <= 1'b0;
         last_src_q   <= 1'b0;
         cnt_words_q  <= '0;
         cnt_frames_q <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         busy_q       <= busy_d;
         pref_q       <= pref_d;
         last_src_q   <= last_src_d;
         cnt_words_q  <= cnt_words_d;
         cnt_frames_q <= cnt_frames_d;
      end
   end

   // Next-state: pick a source in idle, release the grant on the tlast handshake
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      unique case (state_q)
         S_IDLE: begin
            if (s0_axis_tvalid && s1_axis_tvalid) begin
               state_d = S_GRANT;
               grant_d = pref_q;
            end else if (s0_axis_tvalid) begin
               state_d = S_GRANT;
               grant_d = 1'b0;
            end else if (s1_axis_tvalid) begin
               state_d = S_GRANT;
               grant_d = 1'b1;
            end
         end
         S_GRANT: begin
            if (hs_last) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_GRANT);
   end

   // Bookkeeping: preference, last source and counters; clear beats a coincident increment
   always_comb begin
      pref_d       = pref_q;
      last_src_d   = last_src_q;
      cnt_words_d  = cnt_words_q;
      cnt_frames_d = cnt_frames_q;
      if (hs_last) begin
         last_src_d = grant_q;
`ifdef AXIS_ARB_FIXED_PRIO_EN
         pref_d     = 1'b0;
`else
         pref_d     = ~grant_q;
`endif
      end
      if (clr_cnt) begin
         cnt_words_d  = '0;
         cnt_frames_d = '0;
      end else begin
         if (hs) begin
            cnt_words_d = cnt_words_q + CNT_W'(1);
         end
         if (hs_last) begin
            cnt_frames_d = cnt_frames_q + CNT_W'(1);
         end
      end
   end

   // Output: combinational pass-through of the granted source
   always_comb begin
      m_axis_tdata   = '0;
      m_axis_tvalid  = 1'b0;
      m_axis_tlast   = 1'b0;
      s0_axis_tready = 1'b0;
      s1_axis_tready = 1'b0;
      if (state_q == S_GRANT) begin
         if (grant_q) begin
            m_axis_tdata   = s1_axis_tdata;
            m_axis_tvalid  = s1_axis_tvalid;
            m_axis_tlast   = s1_axis_tlast;
            s1_axis_tready = m_axis_tready;
         end else begin
            m_axis_tdata   = s0_axis_tdata;
            m_axis_tvalid  = s0_axis_tvalid;
            m_axis_tlast   = s0_axis_tlast;
            s0_axis_tready = m_axis_tready;
         end
      end
   end

   assign busy       = busy_q;
   assign grant_id   = grant_q;
   assign last_src   = last_src_q;
   assign cnt_words  = cnt_words_q;
   assign cnt_frames = cnt_frames_q;

endmodule

// File: tb/tb_axis_s2mm_arbiter.sv
// Bench for axis_s2mm_arbiter: directed scenarios plus random traffic against a frame-level model.
// Honours AXIS_ARB_FIXED_PRIO_EN to select the expected arbitration policy.
module tb_axis_s2mm_arbiter;

   localparam int unsigned DW = 32;
`ifdef AXIS_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic          aclk;
   logic          areset;
   logic          s0v, s0l, s1v, s1l, mready, clr;
   logic [DW-1:0] s0d, s1d;
   logic          s0_axis_tready, s1_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid, m_axis_tlast;
   logic          busy, grant_id, last_src;
   logic [31:0]   cnt_words, cnt_frames;

   int checks   = 0;
   int failures = 0;

   // Reference model: who owns the sink, whose turn it is, and the tallies
   logic        mb, mg, mpref, mlast;
   logic [31:0] mw, mf;
   logic        hs0, hs1;

   axis_s2mm_arbiter #(.C_DATA_WIDTH(DW)) dut (
      .aclk           (aclk),
      .areset         (areset),
      .s0_axis_tready (s0_axis_tready),
      .s0_axis_tdata  (s0d),
      .s0_axis_tvalid (s0v),
      .s0_axis_tlast  (s0l),
      .s1_axis_tready (s1_axis_tready),
      .s1_axis_tdata  (s1d),
      .s1_axis_tvalid (s1v),
      .s1_axis_tlast  (s1l),
      .m_axis_tready  (mready),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tlast   (m_axis_tlast),
      .clr_cnt        (clr),
      .busy           (busy),
      .grant_id       (grant_id),
      .last_src       (last_src),
      .cnt_words      (cnt_words),
      .cnt_frames     (cnt_frames)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      mb = 1'b0; mg = 1'b0; mpref = 1'b0; mlast = 1'b0; mw = '0; mf = '0;
   endtask

   // Entered at posedge+1; asserts reset, checks asynchronous clearing, releases after an edge
   task automatic do_reset();
      areset = 1'b1;
      #1;
      chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_s0_tready", 32'(s0_axis_tready), 32'd0);
      chk("rst_s1_tready", 32'(s1_axis_tready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_last_src", 32'(last_src), 32'd0);
      chk("rst_cnt_words", cnt_words, 32'd0);
      chk("rst_cnt_frames", cnt_frames, 32'd0);
      model_reset();
      @(posedge aclk);
      #1;
      areset = 1'b0;
   endtask

   // One clock cycle: check pass-through, advance the model, then check registered outputs
   task automatic cyc();
      logic          ev, el, er0, er1, hs, last_v, nb, ng;
      logic [DW-1:0] ed;
      #2;
      ev = 1'b0; el = 1'b0; ed = '0; er0 = 1'b0; er1 = 1'b0;
      if (mb) begin
         ev  = mg ? s1v : s0v;
         el  = mg ? s1l : s0l;
         ed  = mg ? s1d : s0d;
         er0 = ~mg & mready;
         er1 = mg & mready;
      end
      chk("m_tvalid", 32'(m_axis_tvalid), 32'(ev));
      if (ev) begin
         chk("m_tdata", m_axis_tdata, ed);
         chk("m_tlast", 32'(m_axis_tlast), 32'(el));
      end
      chk("s0_tready", 32'(s0_axis_tready), 32'(er0));
      chk("s1_tready", 32'(s1_axis_tready), 32'(er1));

      hs     = mb & ev & mready;
      last_v = hs & el;
      hs0    = hs & ~mg;
      hs1    = hs & mg;
      nb     = mb;
      ng     = mg;
      if (!mb) begin
         if (s0v && s1v) begin nb = 1'b1; ng = mpref; end
         else if (s0v)   begin nb = 1'b1; ng = 1'b0; end
         else if (s1v)   begin nb = 1'b1; ng = 1'b1; end
      end else if (last_v) begin
         nb    = 1'b0;
         mlast = mg;
         mpref = FIXED ? 1'b0 : ~mg;
      end
      if (clr) begin
         mw = '0; mf = '0;
      end else begin
         mw = mw + 32'(hs);
         mf = mf + 32'(last_v);
      end
      mb = nb;
      mg = ng;

      @(posedge aclk);
      #1;
      chk("busy", 32'(busy), 32'(mb));
      if (mb) chk("grant_id", 32'(grant_id), 32'(mg));
      chk("last_src", 32'(last_src), 32'(mlast));
      chk("cnt_words", cnt_words, mw);
      chk("cnt_frames", cnt_frames, mf);
   endtask

   initial begin
      int idx0, idx1;
      areset = 1'b1;
      s0v = 0; s0l = 0; s1v = 0; s1l = 0; mready = 0; clr = 0;
      s0d = '0; s1d = '0;
      model_reset();
      do_reset();

      // Single source 4-word frame
      mready = 1'b1;
      s0v = 1'b1; s0d = 32'h11; s0l = 1'b0;
      cyc();
      chk("single_busy", 32'(busy), 32'd1);
      chk("single_grant", 32'(grant_id), 32'd0);
      cyc();
      s0d = 32'h22; cyc();
      s0d = 32'h33; cyc();
      s0d = 32'h44; s0l = 1'b1; cyc();
      s0v = 1'b0; s0l = 1'b0;
      chk("single_words", cnt_words, 32'd4);
      chk("single_frames", cnt_frames, 32'd1);
      chk("single_last_src", 32'(last_src), 32'd0);
      chk("single_idle", 32'(busy), 32'd0);
      cyc();

      // Both sources continuously valid with 2-word frames
      do_reset();
      mready = 1'b1; s0v = 1'b1; s1v = 1'b1; idx0 = 0; idx1 = 0;
      for (int i = 0; i < 12; i++) begin
         s0d = 32'h100 + 32'(idx0); s0l = (idx0 % 2 == 1);
         s1d = 32'h200 + 32'(idx1); s1l = (idx1 % 2 == 1);
         cyc();
         if (hs0) idx0++;
         if (hs1) idx1++;
      end
      chk("rr_frames", cnt_frames, 32'd4);
      chk("rr_words", cnt_words, 32'd8);
      chk("rr_s1_words", 32'(idx1), FIXED ? 32'd0 : 32'd4);
      s0v = 1'b0; s1v = 1'b0; s0l = 1'b0; s1l = 1'b0;
      cyc();

      // Backpressure on a 4-word s1 frame
      do_reset();
      mready = 1'b1; s1v = 1'b1; s1d = 32'hA0; s1l = 1'b0;
      cyc();
      cyc();
      s1d = 32'hA1; cyc();
      s1d = 32'hA2; mready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("bp_words_frozen", cnt_words, 32'd2);
         chk("bp_data_stable", m_axis_tdata, 32'hA2);
      end
      mready = 1'b1; cyc();
      s1d = 32'hA3; s1l = 1'b1; cyc();
      chk("bp_words_done", cnt_words, 32'd4);
      s1v = 1'b0; s1l = 1'b0; cyc();

      // Granted s1 stalls mid-frame while s0 waits
      do_reset();
      mready = 1'b1; s1v = 1'b1; s1d = 32'hB0; s1l = 1'b0;
      cyc();
      s0v = 1'b1; s0d = 32'hC0; s0l = 1'b1;
      cyc();
      s1v = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("stall_grant", 32'(grant_id), 32'd1);
         chk("stall_s0_tready", 32'(s0_axis_tready), 32'd0);
      end
      s1v = 1'b1; s1d = 32'hB1; s1l = 1'b1; cyc();
      s1v = 1'b0; s1l = 1'b0; cyc();
      chk("stall_next_grant", 32'(grant_id), 32'd0);
      cyc();
      s0v = 1'b0; s0l = 1'b0; cyc();

      // Clear coincident with a handshake
      do_reset();
      mready = 1'b1; s0v = 1'b1; s0d = 32'hD0; s0l = 1'b0;
      cyc();
      cyc();
      clr = 1'b1; s0d = 32'hD1; cyc();
      chk("clr_words", cnt_words, 32'd0);
      clr = 1'b0; s0d = 32'hD2; s0l = 1'b1; cyc();
      chk("clr_words_after", cnt_words, 32'd1);
      chk("clr_frames_after", cnt_frames, 32'd1);
      s0v = 1'b0; s0l = 1'b0; cyc();

      // Reset in the middle of a frame (do_reset checks before the next edge)
      s0v = 1'b1; s0d = 32'hE0; cyc();
      cyc();
      do_reset();
      s0v = 1'b0; cyc();

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         s0v    = ($urandom % 4) != 0;
         s1v    = ($urandom % 4) != 0;
         s0l    = ($urandom % 3) == 0;
         s1l    = ($urandom % 3) == 0;
         s0d    = $urandom;
         s1d    = $urandom;
         mready = ($urandom % 4) != 0;
         clr    = ($urandom % 25) == 0;
         cyc();
      end
      clr = 1'b0; s0v = 1'b0; s1v = 1'b0;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
